usb_fifo_reader: RTL and testbench
==================================

# usb_fifo_reader

Host-to-FPGA receive path for the Cypress FX2 slave FIFO interface, running on the 20 MHz USB clock. It drains an OUT endpoint and hunts for the "NYAN" frame marker (78, 89, 65, 78) that the send path uses, so both directions share one framing scheme. After the marker it parses address, data and checksum bytes, and presents each verified command to the control register bank through a valid/ready handshake.

## Interface
- FIFO_ADDR, 2'b00, endpoint address driven on fifoad (EP2 OUT).
- clk_usb  in  1  20 MHz USB clock; all logic on its rising edge.
- en  in  1  reset; asynchronous, active-low.
- flag  in  1  endpoint empty flag from the FX2; 1 = empty.
- fd  in  8  FX2 data bus.
- fifoad  out  2  endpoint address; 2'b11 in reset, FIFO_ADDR otherwise.
- sloe  out  1  FIFO output enable, active-low; 1 in reset, 0 otherwise.
- slrd  out  1  FIFO read strobe, active-low; combinational (see Operation).
- slcs  out  1  tied 1.
- pktend  out  1  tied 1.
- cmd_addr  out  8  address of the last good command.
- cmd_data  out  16  data of the last good command, {hi, lo}.
- cmd_valid  out  1  command pending; held until accepted.
- cmd_ready  in  1  consumer accepts the command.
- frame_err  out  1  one-cycle pulse on a checksum failure.
- frame_count  out  16  good frames received; wraps at 65535 to 0.
- err_count  out  8  checksum failures; saturates at 255.
- led1  out  1  1 when out of reset.
- led3  out  1  mirrors cmd_valid.

## Operation
- Reset (en=0) clears the following:
  - state=SYNC0, cmd_valid=0, frame_err=0.
  - cmd_addr=0, cmd_data=0, counters=0.
  - led1=0, sloe=1, fifoad=2'b11, slrd=1.
- Read permission: rd_ok = en & !(state==CSUM & cmd_valid & !cmd_ready).
- slrd = !(rd_ok & !flag).
- A byte is consumed on every rising edge where slrd=0. It is the value of fd at that edge.
- FSM advances only on consumed bytes.
  - SYNC0: 78 goes to SYNC1; any other byte stays in SYNC0.
  - SYNC1: 89 goes to SYNC2; 78 stays in SYNC1; any other byte goes to SYNC0.
  - SYNC2: 65 goes to SYNC3; 78 goes to SYNC1; any other byte goes to SYNC0.
  - SYNC3: 78 goes to ADDR; any other byte goes to SYNC0.
  - ADDR: latch the address byte into a shadow register, then DHI.
  - DHI: latch the data-high byte into a shadow register, then DLO.
  - DLO: latch the data-low byte into a shadow register, then CSUM.
  - CSUM: XOR the three shadow bytes and compare with the consumed byte. Go to SYNC0 in either case.
    - On a match, copy the shadows to cmd_addr/cmd_data, set cmd_valid=1 and increment frame_count.
    - On a mismatch, pulse frame_err, increment err_count (saturating) and leave cmd_* unchanged.
- Handshake: cmd_valid clears on the edge where cmd_valid=1 and cmd_ready=1. A new good frame completing on that same edge sets cmd_valid=1 again, and cmd_* takes the new values.
- Parsing of the next frame continues while a command is pending. Only the CSUM byte stalls (slrd held 1) until the pending command is accepted.
- Only consumed bytes are parsed. Bytes on fd while flag=1 or slrd=1 are ignored.

## Timing
- The byte consumed at edge k updates state at edge k.
- The CSUM byte consumed at edge k gives:
  - cmd_valid=1 or frame_err=1 visible after edge k;
  - frame_err low again after edge k+1.
- Minimum frame length is 8 consumed bytes. Peak throughput is one frame per 8 cycles with cmd_ready=1.
- flag rising mid-frame stalls reads with no state change, and parsing resumes when flag falls.
- Reset asserted mid-frame discards the partial frame and any pending command.
- After en rises, the first read is possible on the first edge.
- The path from cmd_ready to slrd is combinational. The consumer must drive cmd_ready from registers.

## Test plan
- Basic frame:
  - Stimulus: after reset, feed 78,89,65,78,0x12,0xAB,0xCD,0x74 with flag=0 and cmd_ready=0.
  - Response: cmd_valid=1 after the 8th edge, cmd_addr=0x12, cmd_data=0xABCD, frame_count=1.
- Bad checksum:
  - Stimulus: same frame with last byte 0x00.
  - Response: one-cycle frame_err pulse, err_count=1, cmd_valid stays 0.
- Resync:
  - Stimulus: prefix junk 78,78,89,0x05,78 before a good frame.
  - Response: exactly one cmd_valid, and fields correct.
- Backpressure:
  - Stimulus: two back-to-back good frames with cmd_ready=0.
  - Response: slrd=1 while the second CSUM byte is on fd. Raising cmd_ready for one cycle accepts the first command, then the second frame completes with cmd_valid=1 and the new values.
- Empty and reset:
  - Stimulus: toggle flag=1 mid-frame for 3 cycles, then complete the frame.
  - Response: slrd=1 during the stall and a correct decode afterwards.
  - Stimulus: assert en=0 mid-frame.
  - Response: immediate reset values on all outputs, and the next full frame decodes normally.
- Counter limits:
  - Stimulus: force 256 bad frames.
  - Response: err_count stays at 255.

Source files
------------

// File: rtl/usb_fifo_reader_if.sv
// Command handshake between the FX2 receive path and the control register bank.
interface usb_fifo_reader_if;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;

  modport master (
    output cmd_addr,
    output cmd_data,
    output cmd_valid,
    input  cmd_ready
  );

  modport slave (
    input  cmd_addr,
    input  cmd_data,
    input  cmd_valid,
    output cmd_ready
  );
endinterface

// File: rtl/usb_fifo_reader.sv
// FX2 slave-FIFO receive path: hunts for the "NYAN" marker, parses addr/data/checksum,
// and hands verified commands to the register bank over a valid/ready handshake.
module usb_fifo_reader #(
  parameter logic [1:0] FIFO_ADDR = 2'b00
) (
  input  logic                     clk_usb,
  input  logic                     en,
  input  logic                     flag,
  input  logic [7:0]               fd,
  output logic [1:0]               fifoad,
  output logic                     sloe,
  output logic                     slrd,
  output logic                     slcs,
  output logic                     pktend,
  usb_fifo_reader_if.master        cmd,
  output logic                     frame_err,
  output logic [15:0]              frame_count,
  output logic [7:0]               err_count,
  output logic                     led1,
  output logic                     led3
);

  localparam logic [7:0] MARK_N = 8'd78;
  localparam logic [7:0] MARK_Y = 8'd89;
  localparam logic [7:0] MARK_A = 8'd65;

  typedef enum logic [2:0] {
    SYNC0, SYNC1, SYNC2, SYNC3, ADDR, DHI, DLO, CSUM
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        rd_ok;
  logic        consume;
  logic        csum_ok;
  logic [7:0]  sh_addr;
  logic [7:0]  sh_hi;
  logic [7:0]  sh_lo;

  // State register
  always_ff @(posedge clk_usb or negedge en) begin
    if (!en) state <= SYNC0;
    else     state <= state_nxt;
  end

  // Next state: advances only on consumed bytes
  always_comb begin
    state_nxt = state;
    if (consume) begin
      unique case (state)
        SYNC0: if (fd == MARK_N) state_nxt = SYNC1;
        SYNC1: begin
          if (fd == MARK_Y)      state_nxt = SYNC2;
          else if (fd == MARK_N) state_nxt = SYNC1;
          else                   state_nxt = SYNC0;
        end
        SYNC2: begin
          if (fd == MARK_A)      state_nxt = SYNC3;
          else if (fd == MARK_N) state_nxt = SYNC1;
          else                   state_nxt = SYNC0;
        end
        SYNC3:   state_nxt = (fd == MARK_N) ? ADDR : SYNC0;
        ADDR:    state_nxt = DHI;
        DHI:     state_nxt = DLO;
        DLO:     state_nxt = CSUM;
        CSUM:    state_nxt = SYNC0;
        default: state_nxt = SYNC0;
      endcase
    end
  end

  // Outputs; the CSUM byte is held off only while an unaccepted command is pending
  always_comb begin
    rd_ok   = en & ~((state == CSUM) & cmd.cmd_valid & ~cmd.cmd_ready);
    consume = rd_ok & ~flag;
    slrd    = ~consume;
    csum_ok = ((sh_addr ^ sh_hi ^ sh_lo) == fd);
    fifoad  = en ? FIFO_ADDR : 2'b11;
    sloe    = ~en;
    slcs    = 1'b1;
    pktend  = 1'b1;
    led1    = en;
    led3    = cmd.cmd_valid;
  end

  // Shadow capture, command hand-off and counters
  always_ff @(posedge clk_usb or negedge en) begin
    if (!en) begin
      sh_addr       <= '0;
      sh_hi         <= '0;
      sh_lo         <= '0;
      cmd.cmd_addr  <= '0;
      cmd.cmd_data  <= '0;
      cmd.cmd_valid <= 1'b0;
      frame_err     <= 1'b0;
      frame_count   <= '0;
      err_count     <= '0;
    end else begin
      frame_err <= 1'b0;
      if (cmd.cmd_valid && cmd.cmd_ready) cmd.cmd_valid <= 1'b0;
      if (consume) begin
        unique case (state)
          ADDR: sh_addr <= fd;
          DHI:  sh_hi   <= fd;
          DLO:  sh_lo   <= fd;
          CSUM: begin
            if (csum_ok) begin
              // a completing frame wins over an acceptance on the same edge
              cmd.cmd_addr  <= sh_addr;
              cmd.cmd_data  <= {sh_hi, sh_lo};
              cmd.cmd_valid <= 1'b1;
              frame_count   <= frame_count + 16'd1;
            end else begin
              frame_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_fifo_reader.sv
// Bench for usb_fifo_reader: frame table plus hand-written corner sequences,
// with a command scoreboard drained on each valid/ready handshake.
module tb_usb_fifo_reader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } cmd_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] csum;
    logic       good;
  } frame_vec_t;

  logic        clk_usb = 1'b0;
  logic        en      = 1'b0;
  logic        flag    = 1'b1;
  logic [7:0]  fd      = '0;
  logic [1:0]  fifoad;
  logic        sloe, slrd, slcs, pktend;
  logic        frame_err;
  logic [15:0] frame_count;
  logic [7:0]  err_count;
  logic        led1, led3;

  usb_fifo_reader_if cmd_bus ();

  usb_fifo_reader #(.FIFO_ADDR(2'b00)) dut (
    .clk_usb     (clk_usb),
    .en          (en),
    .flag        (flag),
    .fd          (fd),
    .fifoad      (fifoad),
    .sloe        (sloe),
    .slrd        (slrd),
    .slcs        (slcs),
    .pktend      (pktend),
    .cmd         (cmd_bus),
    .frame_err   (frame_err),
    .frame_count (frame_count),
    .err_count   (err_count),
    .led1        (led1),
    .led3        (led3)
  );

  always #25 clk_usb = ~clk_usb;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  cmd_t        sb_q[$];
  logic [15:0] exp_fc = '0;
  logic [7:0]  exp_ec = '0;
  frame_vec_t  vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one byte and return at the falling edge after it has been consumed.
  task automatic send_byte(input logic [7:0] b);
    int unsigned waited = 0;
    fd   = b;
    flag = 1'b0;
    #1;
    while (slrd !== 1'b0 && waited < 50) begin
      @(negedge clk_usb);
      #1;
      waited++;
    end
    if (slrd !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: slrd stuck at %b waiting for byte %0h", slrd, b);
    end
    @(negedge clk_usb);
    flag = 1'b1;
  endtask

  task automatic send_marker();
    send_byte(8'd78);
    send_byte(8'd89);
    send_byte(8'd65);
    send_byte(8'd78);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] c);
    send_marker();
    send_byte(a);
    send_byte(h);
    send_byte(l);
    send_byte(c);
  endtask

  task automatic expect_good(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l);
    sb_q.push_back({a, h, l});
    exp_fc = exp_fc + 16'd1;
  endtask

  task automatic expect_bad();
    if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
  endtask

  task automatic drain();
    cmd_bus.cmd_ready = 1'b1;
    @(negedge clk_usb);
    cmd_bus.cmd_ready = 1'b0;
    chk("drain_valid_clear", {31'd0, cmd_bus.cmd_valid}, 32'd0);
  endtask

  // Scoreboard monitor: samples just before each rising edge
  initial begin
    cmd_t e;
    forever begin
      @(negedge clk_usb);
      #20;
      if (cmd_bus.cmd_valid === 1'b1 && cmd_bus.cmd_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got cmd %0h/%0h expected none",
                   cmd_bus.cmd_addr, cmd_bus.cmd_data);
        end else begin
          e = sb_q.pop_front();
          chk("sb_cmd_addr", {24'd0, cmd_bus.cmd_addr}, {24'd0, e.addr});
          chk("sb_cmd_data", {16'd0, cmd_bus.cmd_data}, {16'd0, e.data});
        end
      end
    end
  end

  initial begin
    vecs[0] = '{addr: 8'h00, hi: 8'h00, lo: 8'h00, csum: 8'h00, good: 1'b1};
    vecs[1] = '{addr: 8'hFF, hi: 8'hFF, lo: 8'hFF, csum: 8'hFF, good: 1'b1};
    vecs[2] = '{addr: 8'h4E, hi: 8'h59, lo: 8'h41, csum: 8'h56, good: 1'b1};
    vecs[3] = '{addr: 8'h80, hi: 8'h01, lo: 8'h02, csum: 8'h83, good: 1'b1};
    vecs[4] = '{addr: 8'h80, hi: 8'h01, lo: 8'h02, csum: 8'h82, good: 1'b0};
    vecs[5] = '{addr: 8'h5A, hi: 8'hA5, lo: 8'h3C, csum: 8'hC3, good: 1'b1};
    vecs[6] = '{addr: 8'h5A, hi: 8'hA5, lo: 8'h3C, csum: 8'h00, good: 1'b0};

    cmd_bus.cmd_ready = 1'b0;
    flag = 1'b0;
    repeat (2) @(negedge clk_usb);
    #1;
    chk("rst_slrd",   {31'd0, slrd}, 32'd1);
    chk("rst_sloe",   {31'd0, sloe}, 32'd1);
    chk("rst_fifoad", {30'd0, fifoad}, 32'd3);
    chk("rst_led1",   {31'd0, led1}, 32'd0);
    chk("rst_valid",  {31'd0, cmd_bus.cmd_valid}, 32'd0);
    chk("rst_fcount", {16'd0, frame_count}, 32'd0);
    chk("rst_ecount", {24'd0, err_count}, 32'd0);
    chk("rst_slcs_pktend", {30'd0, slcs, pktend}, 32'd3);
    flag = 1'b1;
    @(negedge clk_usb);
    en = 1'b1;
    #1;
    chk("run_fifoad_sloe_led1", {28'd0, fifoad, sloe, led1}, 32'b0001);

    // Basic frame, no acceptance
    expect_good(8'h12, 8'hAB, 8'hCD);
    send_frame(8'h12, 8'hAB, 8'hCD, 8'h74);
    chk("basic_valid", {31'd0, cmd_bus.cmd_valid}, 32'd1);
    chk("basic_addr",  {24'd0, cmd_bus.cmd_addr}, 32'h12);
    chk("basic_data",  {16'd0, cmd_bus.cmd_data}, 32'hABCD);
    chk("basic_fcount", {16'd0, frame_count}, {16'd0, exp_fc});
    chk("basic_led3",  {31'd0, led3}, 32'd1);
    drain();

    // Bad checksum
    expect_bad();
    send_frame(8'h12, 8'hAB, 8'hCD, 8'h00);
    chk("bad_err_pulse", {31'd0, frame_err}, 32'd1);
    chk("bad_ecount", {24'd0, err_count}, {24'd0, exp_ec});
    chk("bad_valid",  {31'd0, cmd_bus.cmd_valid}, 32'd0);
    @(negedge clk_usb);
    chk("bad_err_low", {31'd0, frame_err}, 32'd0);

    // Resync through junk prefix
    send_byte(8'd78); send_byte(8'd78); send_byte(8'd89); send_byte(8'h05); send_byte(8'd78);
    expect_good(8'h34, 8'h56, 8'h78);
    send_frame(8'h34, 8'h56, 8'h78, 8'h1A);
    chk("resync_valid",  {31'd0, cmd_bus.cmd_valid}, 32'd1);
    chk("resync_fcount", {16'd0, frame_count}, {16'd0, exp_fc});
    chk("resync_addr",   {24'd0, cmd_bus.cmd_addr}, 32'h34);
    drain();

    // Backpressure: second CSUM stalls until the first command is taken
    expect_good(8'h01, 8'h02, 8'h03);
    send_frame(8'h01, 8'h02, 8'h03, 8'h00);
    send_marker();
    send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
    expect_good(8'h0A, 8'h0B, 8'h0C);
    fd = 8'h0D;
    flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_slrd_stall", {31'd0, slrd}, 32'd1);
      @(negedge clk_usb);
    end
    chk("bp_fcount_hold", {16'd0, frame_count}, {16'd0, exp_fc - 16'd1});
    cmd_bus.cmd_ready = 1'b1;
    #1;
    chk("bp_slrd_release", {31'd0, slrd}, 32'd0);
    @(negedge clk_usb);
    cmd_bus.cmd_ready = 1'b0;
    flag = 1'b1;
    chk("bp_valid2", {31'd0, cmd_bus.cmd_valid}, 32'd1);
    chk("bp_addr2",  {24'd0, cmd_bus.cmd_addr}, 32'h0A);
    chk("bp_data2",  {16'd0, cmd_bus.cmd_data}, 32'h0B0C);
    chk("bp_fcount", {16'd0, frame_count}, {16'd0, exp_fc});
    drain();

    // Empty-flag stall mid-frame
    send_marker();
    send_byte(8'h21);
    fd = 8'hEE;
    flag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("empty_slrd", {31'd0, slrd}, 32'd1);
      @(negedge clk_usb);
    end
    expect_good(8'h21, 8'h43, 8'h65);
    send_byte(8'h43); send_byte(8'h65); send_byte(8'h07);
    chk("empty_valid", {31'd0, cmd_bus.cmd_valid}, 32'd1);
    chk("empty_data",  {16'd0, cmd_bus.cmd_data}, 32'h4365);
    drain();

    // Table-driven frames with the consumer always ready
    cmd_bus.cmd_ready = 1'b1;
    foreach (vecs[i]) begin
      if (vecs[i].good) expect_good(vecs[i].addr, vecs[i].hi, vecs[i].lo);
      else              expect_bad();
      send_frame(vecs[i].addr, vecs[i].hi, vecs[i].lo, vecs[i].csum);
      chk("tbl_valid",  {31'd0, cmd_bus.cmd_valid}, {31'd0, vecs[i].good});
      chk("tbl_err",    {31'd0, frame_err}, {31'd0, ~vecs[i].good});
      chk("tbl_fcount", {16'd0, frame_count}, {16'd0, exp_fc});
      chk("tbl_ecount", {24'd0, err_count}, {24'd0, exp_ec});
      @(negedge clk_usb);
      chk("tbl_idle_err",   {31'd0, frame_err}, 32'd0);
      chk("tbl_idle_valid", {31'd0, cmd_bus.cmd_valid}, 32'd0);
    end

    // Error counter saturation
    for (int i = 0; i < 256; i++) begin
      expect_bad();
      send_frame(i[7:0], 8'h00, 8'h00, i[7:0] ^ 8'h01);
      chk("sat_ecount", {24'd0, err_count}, {24'd0, exp_ec});
    end
    chk("sat_final", {24'd0, err_count}, 32'd255);
    cmd_bus.cmd_ready = 1'b0;

    // Reset mid-frame with a command pending
    expect_good(8'hC0, 8'hDE, 8'hAD);
    send_frame(8'hC0, 8'hDE, 8'hAD, 8'hB3);
    send_marker();
    send_byte(8'h99); send_byte(8'h88);
    en = 1'b0;
    #1;
    sb_q.delete();
    exp_fc = '0;
    exp_ec = '0;
    chk("mrst_valid",  {31'd0, cmd_bus.cmd_valid}, 32'd0);
    chk("mrst_outs",   {27'd0, fifoad, sloe, slrd, led1}, 32'b11110);
    chk("mrst_cmd",    {8'd0, cmd_bus.cmd_addr, cmd_bus.cmd_data}, 32'd0);
    chk("mrst_counts", {8'd0, frame_count, err_count}, 32'd0);
    chk("mrst_err_led3", {30'd0, frame_err, led3}, 32'd0);
    @(negedge clk_usb);
    en = 1'b1;
    expect_good(8'h10, 8'h20, 8'h30);
    send_frame(8'h10, 8'h20, 8'h30, 8'h00);
    chk("post_rst_valid",  {31'd0, cmd_bus.cmd_valid}, 32'd1);
    chk("post_rst_fcount", {16'd0, frame_count}, {16'd0, exp_fc});
    chk("post_rst_addr",   {24'd0, cmd_bus.cmd_addr}, 32'h10);
    drain();

    repeat (2) @(negedge clk_usb);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
